airi5c_float_multiplier_iter: RTL and testbench

Parametrised iterative mantissa multiplier for the FPU. It replaces the fixed single-precision shift-add multiplier with one generic over mantissa width, exponent width and bits retired per cycle, so SP and DP instances share one RTL. It sits between the operand classifier (unpacked man/exp/flags in) and the shared rounding/normalisation stage (man/exp/sgn/round/sticky out).

---
 rtl/airi5c_float_multiplier_iter.sv | 198 +++++++++++++++++++
 tb/tb_airi5c_float_multiplier_iter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/airi5c_float_multiplier_iter.sv
`default_nettype none
// ============================================================================
// Module   : airi5c_float_multiplier_iter
// Purpose  : Iterative mantissa multiplier for the FPU. It retires BPC
//            multiplier bits per cycle and is generic over mantissa and
//            exponent width, so SP and DP instances share one RTL. Special
//            operands (NaN/inf/zero) are resolved directly on load.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module airi5c_float_multiplier_iter #(
  parameter int MAN_W   = 24,
  parameter int EXP_W   = 10,
  parameter int BPC     = 6,
  parameter int INF_EXP = 255
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             kill,
  input  logic             load,
  input  logic             op_mul,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic             sgn_a,
  input  logic             sgn_b,
  input  logic             zero_a,
  input  logic             zero_b,
  input  logic             inf_a,
  input  logic             inf_b,
  input  logic             sNaN_a,
  input  logic             sNaN_b,
  input  logic             qNaN_a,
  input  logic             qNaN_b,
  output logic [MAN_W-1:0] man_y,
  output logic [EXP_W-1:0] exp_y,
  output logic             sgn_y,
  output logic             round_bit,
  output logic             sticky_bit,
  output logic             IV,
  output logic             final_res,
  output logic             busy,
  output logic             ready
);

  localparam int N     = MAN_W / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int RES_W = 2 * MAN_W;
  localparam int ACC_W = MAN_W + BPC;

  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(N - 1);
  localparam logic [EXP_W-1:0] C_INF_EXP  = EXP_W'(INF_EXP);

  // The step count must be an integer number of BPC-wide slices.
  if (MAN_W % BPC != 0) begin : g_bpc_check
    $error("airi5c_float_multiplier_iter: BPC must divide MAN_W");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [RES_W-1:0] r_res;
  logic [MAN_W-1:0] r_man_b;
  logic [EXP_W-1:0] r_exp;
  logic             r_sgn;
  logic             r_iv;
  logic             r_final;
  logic             r_ready;

  logic             w_iv;
  logic             w_nan;
  logic             w_inf;
  logic             w_zero;
  logic             w_clear;
  logic [ACC_W-1:0] w_acc;
  logic [RES_W-1:0] w_res_next;
  logic             w_top;
  logic             w_inc;

  assign w_iv    = sNaN_a | sNaN_b | (zero_a & inf_b) | (inf_a & zero_b);
  assign w_nan   = w_iv | qNaN_a | qNaN_b;
  assign w_inf   = inf_a | inf_b;
  assign w_zero  = zero_a | zero_b;
  assign w_clear = kill | (load & ~op_mul);

  // Partial product: upper half of the running result plus man_b weighted
  // by each of the BPC low multiplier bits still sitting in res.
  always_comb begin
    w_acc = {{BPC{1'b0}}, r_res[RES_W-1:MAN_W]};
    for (int i = 0; i < BPC; i++) begin
      if (r_res[i]) begin
        w_acc = w_acc + (ACC_W'(r_man_b) << i);
      end
    end
  end

  // Shift the consumed multiplier bits out and the new partial sum in.
  if (BPC < MAN_W) begin : g_shift
    assign w_res_next = {w_acc, r_res[MAN_W-1:BPC]};
  end else begin : g_full
    assign w_res_next = w_acc;
  end

  // Control and datapath registers; clear path mirrors reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_res   <= '0;
      r_man_b <= '0;
      r_exp   <= '0;
      r_sgn   <= 1'b0;
      r_iv    <= 1'b0;
      r_final <= 1'b0;
      r_ready <= 1'b0;
    end else if (w_clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_res   <= '0;
      r_man_b <= '0;
      r_exp   <= '0;
      r_sgn   <= 1'b0;
      r_iv    <= 1'b0;
      r_final <= 1'b0;
      r_ready <= 1'b0;
    end else if (load) begin
      r_iv  <= w_iv;
      r_cnt <= '0;
      if (w_nan) begin
        r_res   <= {2'b11, {(RES_W-2){1'b0}}};
        r_exp   <= C_INF_EXP;
        r_sgn   <= 1'b0;
        r_final <= 1'b1;
        r_ready <= 1'b1;
        r_state <= IDLE;
      end else if (w_inf) begin
        r_res   <= {1'b1, {(RES_W-1){1'b0}}};
        r_exp   <= C_INF_EXP;
        r_sgn   <= sgn_a ^ sgn_b;
        r_final <= 1'b1;
        r_ready <= 1'b1;
        r_state <= IDLE;
      end else if (w_zero) begin
        r_res   <= '0;
        r_exp   <= '0;
        r_sgn   <= sgn_a ^ sgn_b;
        r_final <= 1'b1;
        r_ready <= 1'b1;
        r_state <= IDLE;
      end else begin
        r_res   <= {{MAN_W{1'b0}}, man_a};
        r_man_b <= man_b;
        r_exp   <= exp_a + exp_b;
        r_sgn   <= sgn_a ^ sgn_b;
        r_final <= 1'b0;
        r_ready <= 1'b0;
        r_state <= CALC;
      end
    end else begin
      case (r_state)
        CALC: begin
          r_res <= w_res_next;
          if (r_cnt == C_LAST_CNT) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Pick the normalisation window: a product with its MSB set (or a
  // preformatted special value) uses the top half; otherwise shift by one.
  assign w_top = r_res[RES_W-1] | r_final;
  assign w_inc = r_res[RES_W-1] & ~r_final;

  assign man_y      = w_top ? r_res[RES_W-1:MAN_W] : r_res[RES_W-2:MAN_W-1];
  assign exp_y      = r_exp + EXP_W'(w_inc);
  assign round_bit  = w_top ? r_res[MAN_W-1] : r_res[MAN_W-2];
  assign sticky_bit = w_top ? (|r_res[MAN_W-2:0]) : (|r_res[MAN_W-3:0]);
  assign sgn_y      = r_sgn;
  assign IV         = r_iv;
  assign final_res  = r_final;
  assign ready      = r_ready;
  assign busy       = (r_state == CALC);

endmodule
`default_nettype wire

// File: tb/tb_airi5c_float_multiplier_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_airi5c_float_multiplier_iter
// Purpose  : Directed self-checking bench for the iterative multiplier.
//            Instances: SP with BPC=6, SP with BPC=4, DP with BPC=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_airi5c_float_multiplier_iter;

  logic clk, n_reset, kill, load, op_mul;
  logic sgn_a, sgn_b;
  logic zero_a, zero_b, inf_a, inf_b, snan_a, snan_b, qnan_a, qnan_b;

  logic [23:0] s_man_a, s_man_b;
  logic [9:0]  s_exp_a, s_exp_b;
  logic [52:0] d_man_a, d_man_b;
  logic [12:0] d_exp_a, d_exp_b;

  logic [23:0] a_man_y;  logic [9:0]  a_exp_y;
  logic a_sgn, a_round, a_sticky, a_iv, a_final, a_busy, a_ready;
  logic [23:0] b_man_y;  logic [9:0]  b_exp_y;
  logic b_sgn, b_round, b_sticky, b_iv, b_final, b_busy, b_ready;
  logic [52:0] d_man_y;  logic [12:0] d_exp_y;
  logic d_sgn, d_round, d_sticky, d_iv, d_final, d_busy, d_ready;

  logic [38:0] sp6_vec, sp4_vec;
  logic [70:0] dp_vec;
  assign sp6_vec = {a_man_y, a_exp_y, a_sgn, a_round, a_sticky, a_iv, a_final};
  assign sp4_vec = {b_man_y, b_exp_y, b_sgn, b_round, b_sticky, b_iv, b_final};
  assign dp_vec  = {d_man_y, d_exp_y, d_sgn, d_round, d_sticky, d_iv, d_final};

  int checks = 0;
  int failures = 0;

  airi5c_float_multiplier_iter #(.MAN_W(24), .EXP_W(10), .BPC(6), .INF_EXP(255)) u_sp6 (
    .clk(clk), .n_reset(n_reset), .kill(kill), .load(load), .op_mul(op_mul),
    .man_a(s_man_a), .man_b(s_man_b), .exp_a(s_exp_a), .exp_b(s_exp_b),
    .sgn_a(sgn_a), .sgn_b(sgn_b), .zero_a(zero_a), .zero_b(zero_b),
    .inf_a(inf_a), .inf_b(inf_b), .sNaN_a(snan_a), .sNaN_b(snan_b),
    .qNaN_a(qnan_a), .qNaN_b(qnan_b),
    .man_y(a_man_y), .exp_y(a_exp_y), .sgn_y(a_sgn), .round_bit(a_round),
    .sticky_bit(a_sticky), .IV(a_iv), .final_res(a_final), .busy(a_busy), .ready(a_ready)
  );

  airi5c_float_multiplier_iter #(.MAN_W(24), .EXP_W(10), .BPC(4), .INF_EXP(255)) u_sp4 (
    .clk(clk), .n_reset(n_reset), .kill(kill), .load(load), .op_mul(op_mul),
    .man_a(s_man_a), .man_b(s_man_b), .exp_a(s_exp_a), .exp_b(s_exp_b),
    .sgn_a(sgn_a), .sgn_b(sgn_b), .zero_a(zero_a), .zero_b(zero_b),
    .inf_a(inf_a), .inf_b(inf_b), .sNaN_a(snan_a), .sNaN_b(snan_b),
    .qNaN_a(qnan_a), .qNaN_b(qnan_b),
    .man_y(b_man_y), .exp_y(b_exp_y), .sgn_y(b_sgn), .round_bit(b_round),
    .sticky_bit(b_sticky), .IV(b_iv), .final_res(b_final), .busy(b_busy), .ready(b_ready)
  );

  airi5c_float_multiplier_iter #(.MAN_W(53), .EXP_W(13), .BPC(1), .INF_EXP(2047)) u_dp (
    .clk(clk), .n_reset(n_reset), .kill(kill), .load(load), .op_mul(op_mul),
    .man_a(d_man_a), .man_b(d_man_b), .exp_a(d_exp_a), .exp_b(d_exp_b),
    .sgn_a(sgn_a), .sgn_b(sgn_b), .zero_a(zero_a), .zero_b(zero_b),
    .inf_a(inf_a), .inf_b(inf_b), .sNaN_a(snan_a), .sNaN_b(snan_b),
    .qNaN_a(qnan_a), .qNaN_b(qnan_b),
    .man_y(d_man_y), .exp_y(d_exp_y), .sgn_y(d_sgn), .round_bit(d_round),
    .sticky_bit(d_sticky), .IV(d_iv), .final_res(d_final), .busy(d_busy), .ready(d_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rdy(input int w);
    return (w == 0) ? a_ready : (w == 1) ? b_ready : d_ready;
  endfunction

  function automatic logic bsy(input int w);
    return (w == 0) ? a_busy : (w == 1) ? b_busy : d_busy;
  endfunction

  // fl = {zero_a, inf_a, snan_a, qnan_a, zero_b, inf_b, snan_b, qnan_b}
  task automatic apply_flags(input logic [7:0] fl);
    {zero_a, inf_a, snan_a, qnan_a, zero_b, inf_b, snan_b, qnan_b} = fl;
  endtask

  // Present one op_mul load; returns at the negedge following the load edge.
  task automatic sp_load(input logic [23:0] ma, input logic [23:0] mb,
                         input logic [9:0] ea, input logic [9:0] eb,
                         input logic sa, input logic sb, input logic [7:0] fl);
    @(negedge clk);
    s_man_a = ma; s_man_b = mb; s_exp_a = ea; s_exp_b = eb;
    sgn_a = sa; sgn_b = sb; apply_flags(fl);
    op_mul = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0; apply_flags(8'h00);
  endtask

  task automatic dp_load(input logic [52:0] ma, input logic [52:0] mb,
                         input logic [12:0] ea, input logic [12:0] eb,
                         input logic sa, input logic sb, input logic [7:0] fl);
    @(negedge clk);
    d_man_a = ma; d_man_b = mb; d_exp_a = ea; d_exp_b = eb;
    sgn_a = sa; sgn_b = sb; apply_flags(fl);
    op_mul = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0; apply_flags(8'h00);
  endtask

  // Count cycles after the load edge until ready, and busy cycles seen.
  task automatic wait_ready(input int w, output int cyc, output int bc);
    cyc = 0;
    bc  = bsy(w) ? 1 : 0;
    while (!rdy(w) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bsy(w)) bc++;
    end
  endtask

  task automatic test_reset;
    n_reset = 1'b0; kill = 1'b0; load = 1'b0; op_mul = 1'b0;
    sgn_a = 1'b0; sgn_b = 1'b0; apply_flags(8'h00);
    s_man_a = '0; s_man_b = '0; s_exp_a = '0; s_exp_b = '0;
    d_man_a = '0; d_man_b = '0; d_exp_a = '0; d_exp_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sp6_vec, a_busy, a_ready} !== 41'h0) begin
      failures++; $display("FAIL reset_sp6 got=%h want=0", {sp6_vec, a_busy, a_ready});
    end
    checks++;
    if ({dp_vec, d_busy, d_ready} !== 73'h0) begin
      failures++; $display("FAIL reset_dp got=%h want=0", {dp_vec, d_busy, d_ready});
    end
    n_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal;
    int cyc, bc;
    sp_load(24'hC00000, 24'hC00000, 10'd0, 10'd0, 1'b0, 1'b0, 8'h00);
    wait_ready(0, cyc, bc);
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL n1_latency got=%0d want=4", cyc); end
    checks++;
    if (bc !== 4) begin failures++; $display("FAIL n1_busy_cycles got=%0d want=4", bc); end
    checks++;
    if (sp6_vec !== {24'h900000, 10'd1, 5'b00000}) begin
      failures++; $display("FAIL n1_result got=%h want=%h", sp6_vec, {24'h900000, 10'd1, 5'b00000});
    end
    @(negedge clk);
    checks++;
    if ({a_ready, sp6_vec} !== {1'b0, 24'h900000, 10'd1, 5'b00000}) begin
      failures++; $display("FAIL n1_pulse_hold got=%h", {a_ready, sp6_vec});
    end
    sp_load(24'h800000, 24'h800000, 10'd3, 10'd4, 1'b1, 1'b0, 8'h00);
    wait_ready(0, cyc, bc);
    checks++;
    if (sp6_vec !== {24'h800000, 10'd7, 5'b10000} || cyc !== 4) begin
      failures++; $display("FAIL n2_result got=%h cyc=%0d want=%h cyc=4", sp6_vec, cyc, {24'h800000, 10'd7, 5'b10000});
    end
  endtask

  task automatic test_rounding;
    int cyc, bc;
    sp_load(24'hFFFFFF, 24'hFFFFFF, 10'd10, 10'd20, 1'b0, 1'b0, 8'h00);
    wait_ready(0, cyc, bc);
    checks++;
    if (sp6_vec !== {24'hFFFFFE, 10'd31, 5'b00100} || cyc !== 4) begin
      failures++; $display("FAIL r_bpc6 got=%h cyc=%0d want=%h cyc=4", sp6_vec, cyc, {24'hFFFFFE, 10'd31, 5'b00100});
    end
    sp_load(24'hFFFFFF, 24'hFFFFFF, 10'd10, 10'd20, 1'b0, 1'b0, 8'h00);
    wait_ready(1, cyc, bc);
    checks++;
    if (cyc !== 6 || bc !== 6) begin
      failures++; $display("FAIL r_bpc4_latency got=%0d/%0d want=6/6", cyc, bc);
    end
    checks++;
    if (sp4_vec !== {24'hFFFFFE, 10'd31, 5'b00100}) begin
      failures++; $display("FAIL r_bpc4_result got=%h want=%h", sp4_vec, {24'hFFFFFE, 10'd31, 5'b00100});
    end
  endtask

  task automatic test_special;
    int cyc, bc;
    // inf * zero -> invalid, canonical NaN
    sp_load(24'h800000, 24'h800000, 10'd5, 10'd5, 1'b1, 1'b1, 8'b0100_1000);
    wait_ready(0, cyc, bc);
    checks++;
    if (cyc !== 0 || bc !== 0) begin
      failures++; $display("FAIL s_nan_latency got=%0d/%0d want=0/0", cyc, bc);
    end
    checks++;
    if (sp6_vec !== {24'hC00000, 10'h0FF, 5'b00011}) begin
      failures++; $display("FAIL s_inf_zero got=%h want=%h", sp6_vec, {24'hC00000, 10'h0FF, 5'b00011});
    end
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0) begin failures++; $display("FAIL s_ready_pulse got=%b want=0", a_ready); end
    // inf * normal, negative
    sp_load(24'hA00000, 24'hC00000, 10'd5, 10'd5, 1'b0, 1'b1, 8'b0100_0000);
    checks++;
    if (sp6_vec !== {24'h800000, 10'h0FF, 5'b10001} || a_ready !== 1'b1) begin
      failures++; $display("FAIL s_inf got=%h rdy=%b want=%h rdy=1", sp6_vec, a_ready, {24'h800000, 10'h0FF, 5'b10001});
    end
    // zero * normal, negative
    sp_load(24'h000000, 24'hC00000, 10'd5, 10'd5, 1'b1, 1'b0, 8'b1000_0000);
    checks++;
    if (sp6_vec !== {24'h000000, 10'h000, 5'b10001} || a_ready !== 1'b1) begin
      failures++; $display("FAIL s_zero got=%h rdy=%b", sp6_vec, a_ready);
    end
    // signalling NaN -> invalid
    sp_load(24'hC00000, 24'hC00000, 10'd5, 10'd5, 1'b1, 1'b0, 8'b0010_0000);
    checks++;
    if (sp6_vec !== {24'hC00000, 10'h0FF, 5'b00011}) begin
      failures++; $display("FAIL s_snan got=%h want=%h", sp6_vec, {24'hC00000, 10'h0FF, 5'b00011});
    end
  endtask

  task automatic test_kill;
    int cyc, bc, hits;
    sp_load(24'hC00000, 24'hC00000, 10'd3, 10'd3, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checks++;
    if ({sp6_vec, a_busy, a_ready} !== 41'h0) begin
      failures++; $display("FAIL k_clear got=%h want=0", {sp6_vec, a_busy, a_ready});
    end
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_ready) hits++;
    end
    checks++;
    if (hits !== 0) begin failures++; $display("FAIL k_no_ready got=%0d want=0", hits); end
    // non-multiply load clears a held special result
    sp_load(24'h0, 24'h0, 10'd0, 10'd0, 1'b0, 1'b0, 8'b0001_0000);
    load = 1'b1; op_mul = 1'b0;
    @(negedge clk);
    load = 1'b0; op_mul = 1'b1;
    checks++;
    if ({sp6_vec, a_busy, a_ready} !== 41'h0) begin
      failures++; $display("FAIL k_opclear got=%h want=0", {sp6_vec, a_busy, a_ready});
    end
    // restart mid-CALC: only the second op completes
    sp_load(24'hC00000, 24'hC00000, 10'd0, 10'd0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    hits = a_ready ? 1 : 0;
    sp_load(24'h800000, 24'h800000, 10'd3, 10'd4, 1'b1, 1'b0, 8'h00);
    wait_ready(0, cyc, bc);
    checks++;
    if (hits !== 0 || cyc !== 4 || sp6_vec !== {24'h800000, 10'd7, 5'b10000}) begin
      failures++; $display("FAIL k_restart got=%h cyc=%0d early=%0d want=%h cyc=4", sp6_vec, cyc, hits, {24'h800000, 10'd7, 5'b10000});
    end
    // asynchronous reset mid-CALC
    sp_load(24'hC00000, 24'hC00000, 10'd1, 10'd1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    checks++;
    if ({sp6_vec, a_busy, a_ready} !== 41'h0) begin
      failures++; $display("FAIL k_async_reset got=%h want=0", {sp6_vec, a_busy, a_ready});
    end
    @(negedge clk);
    n_reset = 1'b1;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_ready || a_busy) hits++;
    end
    checks++;
    if (hits !== 0) begin failures++; $display("FAIL k_reset_idle got=%0d want=0", hits); end
  endtask

  task automatic test_dp;
    int cyc, bc;
    dp_load(53'h18000000000000, 53'h18000000000000, 13'd100, 13'd200, 1'b0, 1'b0, 8'h00);
    wait_ready(2, cyc, bc);
    checks++;
    if (cyc !== 53 || bc !== 53) begin
      failures++; $display("FAIL d_latency got=%0d/%0d want=53/53", cyc, bc);
    end
    checks++;
    if (dp_vec !== {53'h12000000000000, 13'd301, 5'b00000}) begin
      failures++; $display("FAIL d_result got=%h want=%h", dp_vec, {53'h12000000000000, 13'd301, 5'b00000});
    end
    dp_load(53'h18000000000000, 53'h10000000000000, 13'd100, 13'd200, 1'b1, 1'b0, 8'b0000_0001);
    checks++;
    if (dp_vec !== {53'h18000000000000, 13'h7FF, 5'b00001} || d_ready !== 1'b1) begin
      failures++; $display("FAIL d_qnan got=%h rdy=%b want=%h rdy=1", dp_vec, d_ready, {53'h18000000000000, 13'h7FF, 5'b00001});
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_rounding;
    test_special;
    test_kill;
    test_dp;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
